// File: rtl/instr_loader.sv
// Instruction loader: streams program words into a flat register store and
// holds the core in reset until a complete (or slot-filling) program is in place.
module instr_loader #(
    parameter int unsigned NUM_INSTR = 8,
    parameter int unsigned REG_WIDTH = 32,
    localparam int unsigned CNT_WIDTH = $clog2(NUM_INSTR) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_load_start,
    input  logic                           i_word_valid,
    input  logic [REG_WIDTH-1:0]           i_word_data,
    input  logic                           i_word_last,
    output logic                           o_word_ready,
    output logic [NUM_INSTR*REG_WIDTH-1:0] o_instructions,
    output logic                           o_cpu_rst,
    output logic [CNT_WIDTH-1:0]           o_count,
    output logic                           o_overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       accept;
    logic       clear;
    logic       last_slot;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clear     = 1'b0;
        last_slot = (o_count == CNT_WIDTH'(NUM_INSTR - 1));
        case (state)
            ST_IDLE, ST_RUN: begin
                if (i_load_start) begin
                    state_nxt = ST_LOAD;
                    clear     = 1'b1;
                end
            end
            ST_LOAD: begin
                // Start requests are deliberately ignored while loading
                accept = i_word_valid;
                if (accept && (i_word_last || last_slot)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_word_ready = (state == ST_LOAD);
    assign o_cpu_rst    = rst | (state != ST_RUN);

    // Program store, word count and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_instructions <= '0;
            o_count        <= '0;
            o_overflow     <= 1'b0;
        end else if (clear) begin
            o_instructions <= '0;
            o_count        <= '0;
            o_overflow     <= 1'b0;
        end else if (accept) begin
            for (int unsigned k = 0; k < NUM_INSTR; k++) begin
                if (o_count == CNT_WIDTH'(k)) begin
                    o_instructions[k*REG_WIDTH +: REG_WIDTH] <= i_word_data;
                end
            end
            o_count <= o_count + CNT_WIDTH'(1);
            // Filling the final slot without a last marker means the program was truncated
            if (last_slot && !i_word_last) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus queues expected accepts,
// a monitor checks each accept; directed snapshots check final program state.
module tb_instr_loader;

    localparam int NI = 8;
    localparam int RW = 32;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_load_start = 1'b0;
    logic              i_word_valid = 1'b0;
    logic [RW-1:0]     i_word_data = '0;
    logic              i_word_last = 1'b0;
    logic              o_word_ready;
    logic [NI*RW-1:0]  o_instructions;
    logic              o_cpu_rst;
    logic [CW-1:0]     o_count;
    logic              o_overflow;

    typedef struct {
        int            slot;
        logic [RW-1:0] data;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          run;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    instr_loader #(.NUM_INSTR(NI), .REG_WIDTH(RW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_load_start   (i_load_start),
        .i_word_valid   (i_word_valid),
        .i_word_data    (i_word_data),
        .i_word_last    (i_word_last),
        .o_word_ready   (o_word_ready),
        .o_instructions (o_instructions),
        .o_cpu_rst      (o_cpu_rst),
        .o_count        (o_count),
        .o_overflow     (o_overflow)
    );

    function automatic logic [RW-1:0] slot(input int k);
        return o_instructions[k*RW +: RW];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for exactly one cycle; queue the expected accept if one is due
    task automatic send(input logic [RW-1:0] d, input logic lst, input bit expect_acc);
        exp_t e;
        i_word_valid = 1'b1;
        i_word_data  = d;
        i_word_last  = lst;
        if (expect_acc) begin
            e.slot = exp_cnt;
            e.data = d;
            exp_cnt++;
            e.cnt  = CW'(exp_cnt);
            e.run  = lst || (exp_cnt == NI);
            e.ovf  = !lst && (exp_cnt == NI);
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic start_load();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        exp_cnt      = 0;
    endtask

    task automatic check_prog(input string tag, input logic [RW-1:0] w0, input logic [RW-1:0] w1,
                              input logic [RW-1:0] w2, input logic [CW-1:0] cnt);
        logic [RW-1:0] e;
        for (int k = 0; k < NI; k++) begin
            e = (k == 0) ? w0 : (k == 1) ? w1 : (k == 2) ? w2 : '0;
            chk($sformatf("%s_slot%0d", tag, k), slot(k), e);
        end
        chk({tag, "_count"}, 32'(o_count), 32'(cnt));
        chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
        chk({tag, "_cpu_rst"}, 32'(o_cpu_rst), 32'd0);
        chk({tag, "_ready"}, 32'(o_word_ready), 32'd0);
    endtask

    // Monitor: every handshake the DUT completes must match the next queued expectation
    initial begin : monitor
        logic pend;
        logic rst_at;
        exp_t e;
        forever begin
            @(negedge clk);
            pend = o_word_ready && i_word_valid;
            @(posedge clk);
            rst_at = rst;
            #1;
            if (pend && !rst_at) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got accept with count now %0d, expected no accept", o_count);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("acc_slot%0d", e.slot), slot(e.slot), e.data);
                    chk("acc_count", 32'(o_count), 32'(e.cnt));
                    chk("acc_ovf", 32'(o_overflow), 32'(e.ovf));
                    chk("acc_cpu_rst", 32'(o_cpu_rst), 32'(!e.run));
                    chk("acc_ready", 32'(o_word_ready), 32'(!e.run));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset values
        #1;
        chk("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("rst_ready", 32'(o_word_ready), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_instr_lo", o_instructions[31:0], 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: words ignored without a start request
        for (int i = 0; i < 3; i++) send(32'hDEAD, 1'b0, 1'b0);
        i_word_valid = 1'b0;
        chk("idle_count", 32'(o_count), 32'd0);
        chk("idle_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("idle_ready", 32'(o_word_ready), 32'd0);

        // Basic three-word load
        start_load();
        chk("basic_ready", 32'(o_word_ready), 32'd1);
        chk("basic_cpu_rst_load", 32'(o_cpu_rst), 32'd1);
        send(32'h11, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b1);
        send(32'h33, 1'b1, 1'b1);
        i_word_valid = 1'b0;
        check_prog("basic", 32'h11, 32'h22, 32'h33, 4'd3);

        // Reload from RUN with a single word
        start_load();
        chk("reload_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("reload_count_clr", 32'(o_count), 32'd0);
        chk("reload_slot1_clr", slot(1), 32'd0);
        send(32'h55, 1'b1, 1'b1);
        i_word_valid = 1'b0;
        check_prog("reload", 32'h55, 32'h0, 32'h0, 4'd1);

        // Backpressure gaps of two cycles between words
        start_load();
        send(32'h11, 1'b0, 1'b1);
        i_word_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin tick(); chk("gap1_ready", 32'(o_word_ready), 32'd1); end
        send(32'h22, 1'b0, 1'b1);
        i_word_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin tick(); chk("gap2_ready", 32'(o_word_ready), 32'd1); end
        send(32'h33, 1'b1, 1'b1);
        i_word_valid = 1'b0;
        check_prog("gaps", 32'h11, 32'h22, 32'h33, 4'd3);

        // Start held high throughout a load must not re-clear
        i_load_start = 1'b1;
        tick();
        exp_cnt = 0;
        chk("hold_count_clr", 32'(o_count), 32'd0);
        send(32'h11, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b1);
        send(32'h33, 1'b1, 1'b1);
        i_load_start = 1'b0;
        i_word_valid = 1'b0;
        check_prog("hold", 32'h11, 32'h22, 32'h33, 4'd3);

        // Overflow: eight words without a last marker, ninth rejected
        start_load();
        for (int i = 0; i < NI; i++) send(RW'(32'hA0 + i), 1'b0, 1'b1);
        send(32'hA8, 1'b0, 1'b0);
        i_word_valid = 1'b0;
        tick();
        chk("ovf_slot0", slot(0), 32'hA0);
        chk("ovf_slot7", slot(7), 32'hA7);
        chk("ovf_count", 32'(o_count), 32'd8);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_ready", 32'(o_word_ready), 32'd0);
        chk("ovf_cpu_rst", 32'(o_cpu_rst), 32'd0);
        start_load();
        chk("ovf_restart_flag", 32'(o_overflow), 32'd0);
        chk("ovf_restart_count", 32'(o_count), 32'd0);
        chk("ovf_restart_slot7", slot(7), 32'd0);

        // Asynchronous reset after two of four words
        send(32'h11, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b1);
        i_word_valid = 1'b1;
        i_word_data  = 32'h33;
        i_word_last  = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("arst_ready", 32'(o_word_ready), 32'd0);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_slot0", slot(0), 32'd0);
        chk("arst_slot1", slot(1), 32'd0);
        tick();
        i_word_data = 32'h44;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h66, 1'b0, 1'b0);
        i_word_valid = 1'b0;
        chk("post_rst_count", 32'(o_count), 32'd0);
        chk("post_rst_slot0", slot(0), 32'd0);
        chk("post_rst_cpu_rst", 32'(o_cpu_rst), 32'd1);

        // Recovery load after reset
        start_load();
        send(32'h77, 1'b1, 1'b1);
        i_word_valid = 1'b0;
        check_prog("recover", 32'h77, 32'h0, 32'h0, 4'd1);

        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
